chroma_upsample_buffer: RTL and testbench
=========================================

Name: chroma_upsample_buffer

Overview:
Parametrised successor to the fixed 4:2:0 supersample buffer. It collects one MCU of 8x8 component blocks in a selectable subsampling mode (4:4:4, 4:2:2 or 4:2:0) and replicates chroma by nearest neighbour. It emits one aligned Y/Cb/Cr 8x8 triple per luma block under a valid/ready handshake. It sits between IDCT/level-shift and colour conversion.

Parameters:
IN_W, 9, bit width of each input sample (unsigned)
Q, 8, bit width of each output sample
MAX_Y, 4, luma blocks stored per MCU (must be >= 4)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
mode  input  2  0=4:4:4, 1=4:2:2, 2=4:2:0, 3=reserved (treated as 4:2:0)
valid_in  input  1  block_in/ch_in valid
ready_in  output  1  block accepted when valid_in && ready_in
ch_in  input  2  0=Y, 1=Cb, 2=Cr, 3=invalid
block_in  input  IN_W x [7:0][7:0]  input block, [r][c], [0][0] top-left
y_out  output  Q x [7:0][7:0]  luma block
cb_out  output  Q x [7:0][7:0]  upsampled Cb for current luma block
cr_out  output  Q x [7:0][7:0]  upsampled Cr for current luma block
valid_out  output  1  output triple valid
ready_out  input  1  downstream accepts triple
err  output  1  one-cycle pulse on a discarded out-of-order block

Behaviour:
- Clock is clk; reset is synchronous, active-high; rst is sampled only on the rising edge of clk.
- Reset values: valid_out=0, err=0, ready_in=0 during reset (1 from the first cycle after), y/cb/cr_out=0, state=COLLECT, seq=0, emit_idx=0.
- NY (luma blocks per MCU) = 1/2/4 for mode 4:4:4 / 4:2:2 / 4:2:0.
- mode is latched when the first block of an MCU is accepted (seq==0). Changes to mode mid-MCU are ignored.
- COLLECT state:
  - ready_in=1; the expected sequence is NY Y blocks, then Cb, then Cr.
  - The Y blocks of an MCU arrive in raster order: Y0=TL, Y1=TR, Y2=BL, Y3=BR (4:2:2 uses Y0=L, Y1=R).
  - Accepted block whose ch_in matches the expected channel: stored, seq++.
  - Accepted block whose ch_in mismatches (including ch_in=3): discarded, err=1 for exactly one cycle, seq unchanged.
  - Acceptance of Cr moves the FSM to EMIT. valid_out rises on the next cycle (latency 1 from the Cr handshake).
- EMIT state:
  - ready_in=0; triples are presented in order k=0..NY-1.
  - On valid_out && ready_out: k++. After the last triple, valid_out=0, seq=0, and state returns to COLLECT on the next cycle.
  - While ready_out=0, all outputs are held stable.
- Output mapping for triple k:
  - y_out = Y_k.
  - 4:4:4: cb_out[r][c] = Cb[r][c].
  - 4:2:2: cb_out[r][c] = Cb[r][(8k+c)>>1].
  - 4:2:0, with kr=k>>1, kc=k&1: cb_out[r][c] = Cb[(8kr+r)>>1][(8kc+c)>>1].
  - Cr uses the same mapping as Cb.
- Width rule: each sample is unsigned IN_W bits. A value above 2^Q-1 saturates to 2^Q-1; otherwise the value passes unchanged. Saturation is applied at storage.
- Output data is registered or driven from storage via the emit index; either way it is stable for the whole cycle while valid_out=1.
- Reset asserted mid-COLLECT or mid-EMIT aborts the MCU. Partial data is discarded and the next accepted block is treated as Y0.
- valid_in during EMIT is not accepted (ready_in=0). Upstream holds the block.

Test Plan:
- 4:2:0, ready_out=1: Y0..Y3 constant 10/20/30/40, Cb[r][c]=8r+c, Cr constant 200 -> valid_out rises 1 cycle after the Cr handshake and stays high 4 cycles. Checks:
  - k=0: y=10, cb[0][0]=0, cb[7][7]=27.
  - k=1: y=20, cb[0][0]=4.
  - k=2: y=30, cb[0][0]=32.
  - k=3: y=40, cb[7][7]=63.
  - All triples: cr=200.
- Backpressure: in the same MCU, ready_out=0 for 3 cycles at k=1 -> outputs unchanged; k=2 appears only in the cycle after ready_out returns to 1; ready_in=0 throughout.
- 4:4:4 and 4:2:2: Y=7, Cb ramp 8r+c, Cr=9 -> in 4:4:4, one triple with cb[3][5]=29. In 4:2:2, two triples: k=0 cb[0][7]=3, k=1 cb[0][0]=4.
- Saturation: Y block all 300 (IN_W=9, Q=8) -> y_out all 255. Y block all 255 -> y_out all 255.
- Order error: in 4:2:0, send Cb when Y1 is expected -> err pulses 1 cycle, block dropped, seq stays at 1. A subsequent correct Y1..Cr completes normally with 4 triples.
- Reset mid-EMIT (at k=2): valid_out=0 the cycle after rst; ready_in=1 after rst is released; a fresh 4:4:4 MCU then emits one correct triple.

Source files
------------

// File: rtl/chroma_upsample_buffer.sv
// Collects one MCU of 8x8 blocks (4:4:4, 4:2:2 or 4:2:0) and emits one Y/Cb/Cr
// triple per luma block, with chroma replicated by nearest neighbour.
module chroma_upsample_buffer #(
  parameter int IN_W  = 9,
  parameter int Q     = 8,
  parameter int MAX_Y = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   mode,
  input  logic                         valid_in,
  output logic                         ready_in,
  input  logic [1:0]                   ch_in,
  input  logic [7:0][7:0][IN_W-1:0]    block_in,
  output logic [7:0][7:0][Q-1:0]       y_out,
  output logic [7:0][7:0][Q-1:0]       cb_out,
  output logic [7:0][7:0][Q-1:0]       cr_out,
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic                         err
);

  localparam int IDX_W = $clog2(MAX_Y);
  localparam int SEQ_W = $clog2(MAX_Y + 2);

  typedef enum logic {
    COLLECT,
    EMIT
  } state_t;

  typedef logic [7:0][7:0][Q-1:0] blk_t;

  state_t             state;
  state_t             state_next;
  logic [SEQ_W-1:0]   seq;
  logic [IDX_W-1:0]   emit_idx;
  logic [1:0]         mode_lat;
  logic [SEQ_W-1:0]   ny;
  logic [1:0]         exp_ch;
  logic               ch_ok;
  logic               accept;
  logic               last_triple;
  logic [2:0]         src_r;
  logic [2:0]         src_c;
  blk_t               sat_blk;
  blk_t               y_mem [MAX_Y];
  blk_t               cb_mem;
  blk_t               cr_mem;

  function automatic logic [Q-1:0] sat(input logic [IN_W-1:0] v);
    if ((v >> Q) != '0) sat = '1;
    else                sat = Q'(v);
  endfunction

  // Reserved mode 3 behaves like 4:2:0.
  always_comb begin
    case (mode_lat)
      2'd0:    ny = SEQ_W'(1);
      2'd1:    ny = SEQ_W'(2);
      default: ny = SEQ_W'(4);
    endcase
  end

  always_comb begin
    if (seq < ny)       exp_ch = 2'd0;
    else if (seq == ny) exp_ch = 2'd1;
    else                exp_ch = 2'd2;
  end

  assign ready_in    = (state == COLLECT) && !rst;
  assign accept      = valid_in && ready_in;
  assign ch_ok       = (ch_in == exp_ch);
  assign valid_out   = (state == EMIT);
  assign last_triple = (emit_idx == IDX_W'(ny - SEQ_W'(1)));

  always_comb begin
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        sat_blk[r][c] = sat(block_in[r][c]);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (accept && ch_ok && exp_ch == 2'd2) state_next = EMIT;
      EMIT:    if (ready_out && last_triple)          state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // Mode is captured on any handshake at seq 0; a rejected first block is
  // simply re-latched by the next one since seq does not move.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq      <= '0;
      emit_idx <= '0;
      mode_lat <= 2'd0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (accept) begin
        if (seq == '0) mode_lat <= mode;
        if (ch_ok) seq <= seq + SEQ_W'(1);
        else       err <= 1'b1;
      end
      if (state == EMIT && ready_out) begin
        if (last_triple) begin
          emit_idx <= '0;
          seq      <= '0;
        end else begin
          emit_idx <= emit_idx + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && ch_ok) begin
      case (exp_ch)
        2'd0:    y_mem[seq[IDX_W-1:0]] <= sat_blk;
        2'd1:    cb_mem <= sat_blk;
        default: cr_mem <= sat_blk;
      endcase
    end
  end

  // Half-resolution chroma index: the emit index supplies the MSB, the
  // output coordinate halved supplies the rest.
  always_comb begin
    y_out  = '0;
    cb_out = '0;
    cr_out = '0;
    src_r  = 3'd0;
    src_c  = 3'd0;
    if (valid_out) begin
      y_out = y_mem[emit_idx];
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          case (mode_lat)
            2'd0: begin
              src_r = 3'(r);
              src_c = 3'(c);
            end
            2'd1: begin
              src_r = 3'(r);
              src_c = {emit_idx[0], 2'(c >> 1)};
            end
            default: begin
              src_r = {emit_idx[1], 2'(r >> 1)};
              src_c = {emit_idx[0], 2'(c >> 1)};
            end
          endcase
          cb_out[r][c] = cb_mem[src_r][src_c];
          cr_out[r][c] = cr_mem[src_r][src_c];
        end
      end
    end
  end

endmodule

// File: tb/tb_chroma_upsample_buffer.sv
// Bench for chroma_upsample_buffer: directed MCUs plus randomized MCUs, checked
// against an integer reference model of the MCU contents.
module tb_chroma_upsample_buffer;

  typedef logic [7:0][7:0][7:0] oblk_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [1:0]              mode;
  logic                    valid_in;
  logic                    ready_in;
  logic [1:0]              ch_in;
  logic [7:0][7:0][8:0]    block_in;
  oblk_t                   y_out;
  oblk_t                   cb_out;
  oblk_t                   cr_out;
  logic                    valid_out;
  logic                    ready_out;
  logic                    err;

  int n_compared   = 0;
  int n_mismatched = 0;

  int    ry  [4][8][8];
  int    rcb [8][8];
  int    rcr [8][8];
  oblk_t cap_y  [4];
  oblk_t cap_cb [4];
  oblk_t cap_cr [4];

  always #5 clk = ~clk;

  chroma_upsample_buffer #(.IN_W(9), .Q(8), .MAX_Y(4)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .valid_in(valid_in), .ready_in(ready_in), .ch_in(ch_in), .block_in(block_in),
    .y_out(y_out), .cb_out(cb_out), .cr_out(cr_out),
    .valid_out(valid_out), .ready_out(ready_out), .err(err)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    n_compared++;
    assert (obs === expv) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int satv(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int nyOf(input int m);
    return (m == 0) ? 1 : (m == 1) ? 2 : 4;
  endfunction

  function automatic oblk_t expY(input int k);
    oblk_t e;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        e[r][c] = 8'(satv(ry[k][r][c]));
    return e;
  endfunction

  // Nearest-neighbour source sample of the full-image chroma position.
  function automatic oblk_t expC(input int m, input int k, input bit is_cr);
    oblk_t e;
    int sr, sc, v;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (m == 0) begin
          sr = r; sc = c;
        end else if (m == 1) begin
          sr = r; sc = (8 * k + c) / 2;
        end else begin
          sr = (8 * (k / 2) + r) / 2;
          sc = (8 * (k % 2) + c) / 2;
        end
        v = is_cr ? rcr[sr][sc] : rcb[sr][sc];
        e[r][c] = 8'(satv(v));
      end
    end
    return e;
  endfunction

  // kind: 0 = constant v, 1 = ramp 8r+c, 2 = random 0..511
  task automatic fillBlock(input int ch, input int idx, input int kind, input int v);
    int val;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (kind == 0)      val = v;
        else if (kind == 1) val = 8 * r + c;
        else                val = int'($urandom_range(0, 511));
        if (ch == 0)      ry[idx][r][c] = val;
        else if (ch == 1) rcb[r][c] = val;
        else              rcr[r][c] = val;
      end
    end
  endtask

  task automatic fillRandomMcu();
    for (int i = 0; i < 4; i++) fillBlock(0, i, 2, 0);
    fillBlock(1, 0, 2, 0);
    fillBlock(2, 0, 2, 0);
  endtask

  // Presents one block with channel tag ch_send, taken from the model store.
  // Starts and ends on a falling edge; the handshake is on the edge between.
  task automatic applyStimulus(input int ch_send, input int src_ch, input int src_idx);
    int waited = 0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (src_ch == 0)      block_in[r][c] = 9'(ry[src_idx][r][c]);
        else if (src_ch == 1) block_in[r][c] = 9'(rcb[r][c]);
        else                  block_in[r][c] = 9'(rcr[r][c]);
      end
    end
    ch_in    = 2'(ch_send);
    valid_in = 1'b1;
    while (!ready_in && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ready_in_wait", 512'(ready_in), 512'(1));
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic sendMcu(input int m, input bit scramble_mode);
    mode = 2'(m);
    applyStimulus(0, 0, 0);
    if (scramble_mode) mode = 2'($urandom_range(0, 3));
    for (int i = 1; i < nyOf(m); i++) applyStimulus(0, 0, i);
    applyStimulus(1, 1, 0);
    checkOutput("valid_before_cr", 512'(valid_out), 512'(0));
    applyStimulus(2, 2, 0);
    checkOutput("valid_after_cr", 512'(valid_out), 512'(1));
  endtask

  task automatic collectTriples(input int m, input int count, input int bp_k, input int bp_cycles);
    int    waited;
    oblk_t hy, hcb, hcr;
    ready_out = 1'b1;
    for (int k = 0; k < count; k++) begin
      waited = 0;
      while (!valid_out && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      checkOutput($sformatf("valid_k%0d", k), 512'(valid_out), 512'(1));
      checkOutput($sformatf("y_k%0d", k),  y_out,  expY(k));
      checkOutput($sformatf("cb_k%0d", k), cb_out, expC(m, k, 1'b0));
      checkOutput($sformatf("cr_k%0d", k), cr_out, expC(m, k, 1'b1));
      cap_y[k]  = y_out;
      cap_cb[k] = cb_out;
      cap_cr[k] = cr_out;
      if (k == bp_k) begin
        ready_out = 1'b0;
        hy = y_out; hcb = cb_out; hcr = cr_out;
        for (int i = 0; i < bp_cycles; i++) begin
          @(negedge clk);
          checkOutput("bp_y_hold",  y_out,  hy);
          checkOutput("bp_cb_hold", cb_out, hcb);
          checkOutput("bp_cr_hold", cr_out, hcr);
          checkOutput("bp_valid", 512'(valid_out), 512'(1));
          checkOutput("bp_ready_in", 512'(ready_in), 512'(0));
        end
        ready_out = 1'b1;
      end
      @(negedge clk);
    end
    if (count == nyOf(m)) begin
      checkOutput("valid_after_mcu", 512'(valid_out), 512'(0));
      checkOutput("ready_in_after_mcu", 512'(ready_in), 512'(1));
    end
  endtask

  initial begin
    int m;
    rst       = 1'b1;
    mode      = 2'd0;
    valid_in  = 1'b0;
    ready_out = 1'b0;
    ch_in     = 2'd0;
    block_in  = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_ready_in", 512'(ready_in), 512'(0));
    checkOutput("rst_valid_out", 512'(valid_out), 512'(0));
    checkOutput("rst_err", 512'(err), 512'(0));
    checkOutput("rst_y_out", y_out, '0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_in_after_rst", 512'(ready_in), 512'(1));

    $display("[TB] 4:2:0 directed MCU with backpressure at k=1");
    fillBlock(0, 0, 0, 10); fillBlock(0, 1, 0, 20);
    fillBlock(0, 2, 0, 30); fillBlock(0, 3, 0, 40);
    fillBlock(1, 0, 1, 0);  fillBlock(2, 0, 0, 200);
    sendMcu(2, 1'b0);
    collectTriples(2, 4, 1, 3);
    checkOutput("d420_y0", 512'(cap_y[0][0][0]), 512'(10));
    checkOutput("d420_y1", 512'(cap_y[1][0][0]), 512'(20));
    checkOutput("d420_y2", 512'(cap_y[2][0][0]), 512'(30));
    checkOutput("d420_y3", 512'(cap_y[3][7][7]), 512'(40));
    checkOutput("d420_k0_cb00", 512'(cap_cb[0][0][0]), 512'(0));
    checkOutput("d420_k0_cb77", 512'(cap_cb[0][7][7]), 512'(27));
    checkOutput("d420_k1_cb00", 512'(cap_cb[1][0][0]), 512'(4));
    checkOutput("d420_k2_cb00", 512'(cap_cb[2][0][0]), 512'(32));
    checkOutput("d420_k3_cb77", 512'(cap_cb[3][7][7]), 512'(63));
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("d420_cr_k%0d", k), cap_cr[k], {64{8'd200}});

    $display("[TB] 4:4:4 and 4:2:2 directed MCUs");
    fillBlock(0, 0, 0, 7); fillBlock(0, 1, 0, 7);
    fillBlock(1, 0, 1, 0); fillBlock(2, 0, 0, 9);
    sendMcu(0, 1'b0);
    collectTriples(0, 1, -1, 0);
    checkOutput("d444_cb35", 512'(cap_cb[0][3][5]), 512'(29));
    sendMcu(1, 1'b0);
    collectTriples(1, 2, -1, 0);
    checkOutput("d422_k0_cb07", 512'(cap_cb[0][0][7]), 512'(3));
    checkOutput("d422_k1_cb00", 512'(cap_cb[1][0][0]), 512'(4));

    $display("[TB] saturation");
    fillBlock(0, 0, 0, 300);
    sendMcu(0, 1'b0);
    collectTriples(0, 1, -1, 0);
    checkOutput("sat_300", cap_y[0], {64{8'hFF}});
    fillBlock(0, 0, 0, 255);
    sendMcu(0, 1'b0);
    collectTriples(0, 1, -1, 0);
    checkOutput("sat_255", cap_y[0], {64{8'hFF}});

    $display("[TB] out-of-order blocks in 4:2:0");
    fillRandomMcu();
    mode = 2'd2;
    applyStimulus(0, 0, 0);
    checkOutput("ooo_no_err_y0", 512'(err), 512'(0));
    applyStimulus(1, 1, 0);
    checkOutput("ooo_err_cb", 512'(err), 512'(1));
    applyStimulus(0, 0, 1);
    checkOutput("ooo_err_cleared", 512'(err), 512'(0));
    applyStimulus(3, 0, 2);
    checkOutput("ooo_err_ch3", 512'(err), 512'(1));
    applyStimulus(0, 0, 2);
    applyStimulus(0, 0, 3);
    applyStimulus(1, 1, 0);
    applyStimulus(2, 2, 0);
    checkOutput("ooo_valid_after_cr", 512'(valid_out), 512'(1));
    collectTriples(2, 4, -1, 0);

    $display("[TB] reset during emission");
    fillRandomMcu();
    sendMcu(2, 1'b0);
    collectTriples(2, 2, -1, 0);
    ready_out = 1'b0;
    checkOutput("pre_rst_k2_y", y_out, expY(2));
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_valid", 512'(valid_out), 512'(0));
    checkOutput("rst_mid_ready_in", 512'(ready_in), 512'(0));
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_ready_after", 512'(ready_in), 512'(1));
    fillRandomMcu();
    sendMcu(0, 1'b0);
    collectTriples(0, 1, -1, 0);

    $display("[TB] randomized MCUs");
    for (int n = 0; n < 8; n++) begin
      fillRandomMcu();
      m = int'($urandom_range(0, 3));
      sendMcu(m, 1'b1);
      collectTriples(m, nyOf(m), int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
